// File: rtl/display_digit_driver.sv
// Binary-to-7-seg digit code driver: double-dabble conversion for decimal,
// direct nibble copy for hex, then optional leading-zero blanking.
module display_digit_driver #(
    parameter int WIDTH    = 24,
    parameter int DIGITS   = 8,
    parameter int BLANK_LZ = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    input  logic                  mode_hex,
    output logic                  busy,
    output logic                  valid,
    output logic [5*DIGITS-1:0]   digits
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        BLANK
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]    shift_reg;
    logic [BW-1:0]       bcd;
    logic [BW-1:0]       bcd_adj;
    logic [BW+WIDTH-1:0] shifted;
    logic [CW-1:0]       cnt;
    logic                last_step;
    logic [5*DIGITS-1:0] digits_fmt;
    logic [5*DIGITS-1:0] digits_reg;
    logic                valid_reg;
    logic                lead;
    logic [3:0]          nib;

    assign last_step = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (load) begin
                    state_next = mode_hex ? BLANK : SHIFT;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_next = BLANK;
                end
            end
            BLANK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                busy       = 1'b0;
            end
        endcase
    end

    // Double-dabble correction: any BCD digit of 5 or more would overflow
    // past 9 once doubled, so bias it by 3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {bcd_adj, shift_reg} << 1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            shift_reg <= '0;
            bcd       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        cnt <= '0;
                        if (mode_hex) begin
                            shift_reg <= '0;
                            bcd       <= BW'(value);
                        end else begin
                            shift_reg <= value;
                            bcd       <= '0;
                        end
                    end
                end
                SHIFT: begin
                    {bcd, shift_reg} <= shifted;
                    cnt              <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Scan from the most significant digit down; a digit is blanked only
    // while everything above it (and itself) is still zero, never digit 0.
    always_comb begin
        digits_fmt = '1;
        lead       = 1'b1;
        nib        = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib  = bcd[4*i +: 4];
            lead = lead && (nib == 4'd0);
            if ((BLANK_LZ != 0) && lead && (i != 0)) begin
                digits_fmt[5*i +: 5] = 5'b11111;
            end else begin
                digits_fmt[5*i +: 5] = {1'b0, nib};
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            digits_reg <= '1;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= (state == BLANK);
            if (state == BLANK) begin
                digits_reg <= digits_fmt;
            end
        end
    end

    assign valid  = valid_reg;
    assign digits = digits_reg;

endmodule
